gqa_kv_head_broadcast: RTL and testbench
========================================

# gqa_kv_head_broadcast

Streaming replay buffer for grouped-query attention. It accepts the key or value projection stream, which holds one head per group (NUM_GROUPS heads), and re-emits each group's head GROUP_SIZE times. Every query head therefore receives its matching shared K/V tiles, and the result is a NUM_HEADS-head stream. It sits between a grouped K/V linear (or the K transpose) and the per-head attention datapath. Two ping-pong banks let the next group fill while the current group replays.

## Interface

Parameters:
- NUM_HEADS, 12: total query heads.
- NUM_GROUPS, 3: number of K/V heads. NUM_HEADS % NUM_GROUPS == 0 is required, with GROUP_SIZE = NUM_HEADS/NUM_GROUPS.
- DATA_WIDTH, 16: element width in bits.
- COMPUTE_DIM0, 4: tile columns.
- COMPUTE_DIM1, 4: tile rows.
- HEAD_DEPTH, 16: tiles (beats) per head, ≥1.

Ports (clock and reset first):
- clk, input, 1: single clock; all state on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_data, input, DATA_WIDTH × [COMPUTE_DIM0*COMPUTE_DIM1]: incoming K/V tile.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: a beat is accepted when in_valid && in_ready.
- out_data, output, DATA_WIDTH × [COMPUTE_DIM0*COMPUTE_DIM1]: replayed tile.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: a beat is transferred when out_valid && out_ready.
- out_head_idx, output, max(1,$clog2(NUM_HEADS)): query head index of the current out beat.
- out_last, output, 1: final beat (index HEAD_DEPTH-1) of the current head replay.

## Operation

- Storage is two banks, each HEAD_DEPTH × tile registers. Each bank has a full flag.
- Write side:
  - wr_bank and wr_ptr (0..HEAD_DEPTH-1).
  - in_ready = !full[wr_bank].
  - On an accepted beat: bank[wr_bank][wr_ptr] <= in_data and wr_ptr increments.
  - When wr_ptr == HEAD_DEPTH-1, wr_ptr wraps to 0, full[wr_bank] is set and wr_bank toggles.
- Read side:
  - rd_bank, rd_ptr (0..HEAD_DEPTH-1), rep_cnt (0..GROUP_SIZE-1), head_idx (0..NUM_HEADS-1).
  - out_valid = full[rd_bank].
  - out_data = bank[rd_bank][rd_ptr], a combinational read of registers.
  - out_last = (rd_ptr == HEAD_DEPTH-1).
  - out_head_idx = head_idx.
- On an accepted output beat:
  - rd_ptr increments.
  - At rd_ptr == HEAD_DEPTH-1: rd_ptr goes to 0, head_idx increments (wrapping NUM_HEADS-1 → 0), and rep_cnt increments.
  - When rep_cnt == GROUP_SIZE-1 and out_last: rep_cnt goes to 0, full[rd_bank] is cleared and rd_bank toggles.
- Head mapping: out_head_idx h carries group h/GROUP_SIZE data. Groups arrive in order 0..NUM_GROUPS-1 and repeat for every token block.
- Bank access is disjoint by construction: the write side touches only non-full banks and the read side only full banks. Setting full[wr_bank] and clearing full[rd_bank] in the same cycle is legal and both take effect.
- GROUP_SIZE == 1 (plain MHA) is legal: each head is emitted once.
- NUM_GROUPS == 1 (MQA) is legal: one head is replayed NUM_HEADS times.
- out_data, out_head_idx and out_last hold stable while out_valid && !out_ready.
- The block performs no arithmetic; data passes bit-exact.

## Timing

- Reset values:
  - in_ready = 1, out_valid = 0, out_last = 0 when HEAD_DEPTH > 1, out_head_idx = 0, out_data = 0.
  - All pointers and counters are 0, both full flags are 0 and wr_bank = rd_bank = 0.
- Reset assertion mid-stream discards partially written banks and in-progress replays immediately (asynchronously). The first beat after release is treated as beat 0 of group 0.
- Latency: the first output beat of a group is valid in the cycle after that group's last input beat is accepted (one cycle, registered full flag).
- Throughput:
  - Output sustains 1 beat/cycle with out_ready held high.
  - Input sustains 1 beat/cycle while a bank is free.
  - With GROUP_SIZE > 1 the input stalls (in_ready = 0) once both banks are full. It resumes in the cycle after the last beat of the rd_bank's final replay is accepted.
- There is no combinational path from out_ready to in_ready, nor from in_valid to out_valid.

## Test plan

Default bench configuration: NUM_HEADS=4, NUM_GROUPS=2, HEAD_DEPTH=3, COMPUTE 2×2, DATA_WIDTH=8.

1. Basic replay:
   - Stimulus: stream 6 beats, with group0 tiles = 0x10..0x12 and group1 tiles = 0x20..0x22; out_ready = 1.
   - Required: output beats 0x10,11,12,10,11,12,20,21,22,20,21,22. out_head_idx = 0,0,0,1,1,1,2,2,2,3,3,3. out_last is high on every 3rd beat.
   - Required: first out_valid is high 1 cycle after the 3rd input handshake.
2. Back-pressure on the input:
   - Stimulus: hold out_ready = 0 and stream 9 beats.
   - Required: in_ready drops after 6 accepted beats and stays low. out_data holds 0x10.
   - Required: after out_ready is raised, in_ready returns in the cycle after the 6th output handshake.
3. Random out_ready and in_valid (50%) over 8 token blocks:
   - Required: output sequence matches the reference model with no drops or duplicates.
   - Required: out_data and out_head_idx stay stable while stalled.
4. Mode sweep:
   - NUM_GROUPS = NUM_HEADS = 4: each head is emitted once in order.
   - NUM_GROUPS = 1: one head is emitted 4× with out_head_idx 0..3.
   - Required: all outputs bit-exact.
5. Reset mid-replay:
   - Stimulus: assert rst during beat 4 of the output, then restream group0 = 0x30..0x32.
   - Required: outputs go to reset values immediately. Afterwards out_head_idx restarts at 0 with tiles 0x30..0x32, and no stale 0x1x/0x2x data appears.
6. Head index wrap:
   - Stimulus: two consecutive token blocks.
   - Required: out_head_idx goes 3 → 0 at the block boundary, and the groups restart at group0 data.

Source files
------------

// File: rtl/gqa_kv_head_broadcast_if.sv
`default_nettype none
// ============================================================================
// Module   : gqa_kv_head_broadcast_if
// Brief    : K/V tile stream in, per-query-head replayed tile stream out.
// Revision : 1.0 - initial release
// ============================================================================
interface gqa_kv_head_broadcast_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_ELEMS  = 16,
    parameter int IDX_W      = 4
);
    logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] in_data;
    logic                                 in_valid;
    logic                                 in_ready;
    logic [NUM_ELEMS-1:0][DATA_WIDTH-1:0] out_data;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [IDX_W-1:0]                     out_head_idx;
    logic                                 out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_head_idx, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_head_idx, out_last
    );
endinterface
`default_nettype wire

// File: rtl/gqa_kv_head_broadcast.sv
`default_nettype none
// ============================================================================
// Module   : gqa_kv_head_broadcast
// Brief    : Ping-pong replay buffer re-emitting each K/V group head
//            GROUP_SIZE times to form a NUM_HEADS-head stream.
// Revision : 1.0 - initial release
// ============================================================================
module gqa_kv_head_broadcast #(
    parameter int NUM_HEADS    = 12,
    parameter int NUM_GROUPS   = 3,
    parameter int DATA_WIDTH   = 16,
    parameter int COMPUTE_DIM0 = 4,
    parameter int COMPUTE_DIM1 = 4,
    parameter int HEAD_DEPTH   = 16
) (
    input wire clk,
    input wire rst,
    gqa_kv_head_broadcast_if.slave bus
);
    localparam int c_GROUP_SIZE = NUM_HEADS / NUM_GROUPS;
    localparam int c_NUM_ELEMS  = COMPUTE_DIM0 * COMPUTE_DIM1;
    localparam int c_PTR_W      = (HEAD_DEPTH > 1) ? $clog2(HEAD_DEPTH) : 1;
    localparam int c_REP_W      = (c_GROUP_SIZE > 1) ? $clog2(c_GROUP_SIZE) : 1;
    localparam int c_IDX_W      = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;

    localparam logic [c_PTR_W-1:0] c_LAST_PTR  = c_PTR_W'(HEAD_DEPTH - 1);
    localparam logic [c_REP_W-1:0] c_LAST_REP  = c_REP_W'(c_GROUP_SIZE - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_HEAD = c_IDX_W'(NUM_HEADS - 1);

    typedef logic [c_NUM_ELEMS-1:0][DATA_WIDTH-1:0] tile_t;

    tile_t              r_bank [2][HEAD_DEPTH];
    logic [1:0]         r_full;
    logic               r_wr_bank;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic               r_rd_bank;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_REP_W-1:0] r_rep_cnt;
    logic [c_IDX_W-1:0] r_head_idx;

    logic       w_in_fire;
    logic       w_out_fire;
    logic       w_rd_last;
    logic       w_fill_done;
    logic       w_drain_done;
    logic [1:0] w_full_nxt;

    assign bus.in_ready     = !r_full[r_wr_bank];
    assign bus.out_valid    = r_full[r_rd_bank];
    assign bus.out_data     = r_bank[r_rd_bank][r_rd_ptr];
    assign bus.out_last     = w_rd_last;
    assign bus.out_head_idx = r_head_idx;

    assign w_in_fire    = bus.in_valid && !r_full[r_wr_bank];
    assign w_out_fire   = r_full[r_rd_bank] && bus.out_ready;
    assign w_rd_last    = (r_rd_ptr == c_LAST_PTR);
    assign w_fill_done  = w_in_fire && (r_wr_ptr == c_LAST_PTR);
    assign w_drain_done = w_out_fire && w_rd_last && (r_rep_cnt == c_LAST_REP);

    // Fill and drain always target different banks, so both updates apply.
    always_comb begin
        w_full_nxt = r_full;
        if (w_drain_done) w_full_nxt[r_rd_bank] = 1'b0;
        if (w_fill_done)  w_full_nxt[r_wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int d = 0; d < HEAD_DEPTH; d++) begin
                    r_bank[b][d] <= '0;
                end
            end
        end else if (w_in_fire) begin
            r_bank[r_wr_bank][r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_wr_ptr  <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_in_fire) begin
                if (r_wr_ptr == c_LAST_PTR) begin
                    r_wr_ptr  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
            end
        end
    end

    // Head index runs freely across token blocks; it realigns only on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_bank  <= 1'b0;
            r_rd_ptr   <= '0;
            r_rep_cnt  <= '0;
            r_head_idx <= '0;
        end else if (w_out_fire) begin
            if (w_rd_last) begin
                r_rd_ptr   <= '0;
                r_head_idx <= (r_head_idx == c_LAST_HEAD) ? '0 : r_head_idx + c_IDX_W'(1);
                if (r_rep_cnt == c_LAST_REP) begin
                    r_rep_cnt <= '0;
                    r_rd_bank <= ~r_rd_bank;
                end else begin
                    r_rep_cnt <= r_rep_cnt + c_REP_W'(1);
                end
            end else begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_gqa_kv_head_broadcast.sv
`default_nettype none
// ============================================================================
// Module   : tb_gqa_kv_head_broadcast
// Brief    : Directed bench for the GQA K/V head replay buffer (GQA/MHA/MQA).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gqa_kv_head_broadcast;
    localparam int NH = 4;
    localparam int HD = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gqa_kv_head_broadcast_if #(.DATA_WIDTH(8), .NUM_ELEMS(4), .IDX_W(2)) bus_gqa ();
    gqa_kv_head_broadcast_if #(.DATA_WIDTH(8), .NUM_ELEMS(4), .IDX_W(2)) bus_mha ();
    gqa_kv_head_broadcast_if #(.DATA_WIDTH(8), .NUM_ELEMS(4), .IDX_W(2)) bus_mqa ();

    gqa_kv_head_broadcast #(.NUM_HEADS(4), .NUM_GROUPS(2), .DATA_WIDTH(8),
        .COMPUTE_DIM0(2), .COMPUTE_DIM1(2), .HEAD_DEPTH(3))
        u_dut_gqa (.clk(clk), .rst(rst), .bus(bus_gqa));
    gqa_kv_head_broadcast #(.NUM_HEADS(4), .NUM_GROUPS(4), .DATA_WIDTH(8),
        .COMPUTE_DIM0(2), .COMPUTE_DIM1(2), .HEAD_DEPTH(3))
        u_dut_mha (.clk(clk), .rst(rst), .bus(bus_mha));
    gqa_kv_head_broadcast #(.NUM_HEADS(4), .NUM_GROUPS(1), .DATA_WIDTH(8),
        .COMPUTE_DIM0(2), .COMPUTE_DIM1(2), .HEAD_DEPTH(3))
        u_dut_mqa (.clk(clk), .rst(rst), .bus(bus_mqa));

    typedef struct packed {
        logic [7:0] v;
        logic [1:0] h;
        logic       l;
    } exp_t;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] in_q[$];
    exp_t       exp_q[$];
    int         g_first_ov;
    int         g_ir_rise;
    int         g_acc_cyc[$];
    int         g_out_cyc[$];

    // Each element differs so lane swaps are visible; lane 0 carries the tag value.
    function automatic logic [31:0] tile(input logic [7:0] v);
        return {v ^ 8'hC0, v ^ 8'h80, v ^ 8'h40, v};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [31:0] d, input logic r);
        case (sel)
            0: begin bus_gqa.in_valid = v; bus_gqa.in_data = d; bus_gqa.out_ready = r; end
            1: begin bus_mha.in_valid = v; bus_mha.in_data = d; bus_mha.out_ready = r; end
            default: begin bus_mqa.in_valid = v; bus_mqa.in_data = d; bus_mqa.out_ready = r; end
        endcase
    endtask

    task automatic sample(input int sel, output logic ir, output logic ov,
                          output logic [31:0] od, output logic [1:0] oh, output logic ol);
        case (sel)
            0: begin ir = bus_gqa.in_ready; ov = bus_gqa.out_valid; od = bus_gqa.out_data;
                     oh = bus_gqa.out_head_idx; ol = bus_gqa.out_last; end
            1: begin ir = bus_mha.in_ready; ov = bus_mha.out_valid; od = bus_mha.out_data;
                     oh = bus_mha.out_head_idx; ol = bus_mha.out_last; end
            default: begin ir = bus_mqa.in_ready; ov = bus_mqa.out_valid; od = bus_mqa.out_data;
                     oh = bus_mqa.out_head_idx; ol = bus_mqa.out_last; end
        endcase
    endtask

    // One K/V head of HD beats, replayed to heads h0 .. h0+nh-1.
    task automatic push_group(input logic [7:0] base, input int h0, input int nh);
        exp_t e;
        for (int d = 0; d < HD; d++) in_q.push_back(8'(base + d));
        for (int h = h0; h < h0 + nh; h++) begin
            for (int d = 0; d < HD; d++) begin
                e.v = 8'(base + d);
                e.h = 2'(h);
                e.l = (d == HD - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_block(input int gs, input int ng, input logic [7:0] base);
        for (int g = 0; g < ng; g++) push_group(8'(base + 16 * g), g * gs, gs);
    endtask

    task automatic do_reset();
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // rmode: 0 = out_ready low, 1 = high, 2 = random. Entered and left at posedge+1.
    task automatic run(input int sel, input int max_cyc, input int rmode, input bit rnd_in,
                       input bit need_drain, input string tag);
        logic ir, ov, ol, v, r, p_ir, p_stall;
        logic [31:0] od, p_od;
        logic [1:0] oh, p_oh;
        exp_t e;
        p_stall = 1'b0; p_od = '0; p_oh = '0; p_ir = 1'b1;
        g_first_ov = -1; g_ir_rise = -1;
        g_acc_cyc.delete(); g_out_cyc.delete();
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            if (need_drain && in_q.size() == 0 && exp_q.size() == 0) break;
            v = (in_q.size() > 0) && (!rnd_in || $urandom_range(0, 1) == 1);
            r = (rmode == 1) ? 1'b1 : (rmode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
            drive(sel, v, v ? tile(in_q[0]) : 32'h0, r);
            sample(sel, ir, ov, od, oh, ol);
            if (cyc > 0 && !p_ir && ir && g_ir_rise < 0) g_ir_rise = cyc;
            if (ov && g_first_ov < 0) g_first_ov = cyc;
            if (p_stall) begin
                check({tag, " stall_valid"}, 64'(ov), 64'(1));
                check({tag, " stall_data"}, 64'(od), 64'(p_od));
                check({tag, " stall_head"}, 64'(oh), 64'(p_oh));
            end
            if (ov && r) begin
                if (exp_q.size() == 0) begin
                    check({tag, " extra_beat_valid"}, 64'(ov), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check({tag, " data"}, 64'(od), 64'(tile(e.v)));
                    check({tag, " head"}, 64'(oh), 64'(e.h));
                    check({tag, " last"}, 64'(ol), 64'(e.l));
                    g_out_cyc.push_back(cyc);
                end
            end
            if (v && ir) begin
                void'(in_q.pop_front());
                g_acc_cyc.push_back(cyc);
            end
            p_stall = ov && !r; p_od = od; p_oh = oh; p_ir = ir;
            @(posedge clk); #1;
        end
        drive(sel, 1'b0, 32'h0, 1'b0);
        if (need_drain) begin
            check({tag, " outputs_left"}, 64'(exp_q.size()), 64'(0));
            check({tag, " inputs_left"}, 64'(in_q.size()), 64'(0));
        end
    endtask

    initial begin
        logic ir, ov, ol;
        logic [31:0] od;
        logic [1:0] oh;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 32'h0, 1'b0);
        #1 rst = 1'b1;
        #1;
        sample(0, ir, ov, od, oh, ol);
        check("rst in_ready", 64'(ir), 64'(1));
        check("rst out_valid", 64'(ov), 64'(0));
        check("rst out_last", 64'(ol), 64'(0));
        check("rst head_idx", 64'(oh), 64'(0));
        check("rst out_data", 64'(od), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic replay with out_ready high
        push_block(2, 2, 8'h10);
        run(0, 60, 1, 1'b0, 1'b1, "t1");
        check("t1 first_valid_cycle", 64'(g_first_ov), 64'(3));
        check("t1 sixth_accept_cycle", 64'(g_acc_cyc[5]), 64'(5));
        check("t1 last_out_cycle", 64'(g_out_cyc[11]), 64'(14));

        // Input back-pressure: 9 beats offered with out_ready low
        do_reset();
        push_block(2, 2, 8'h10);
        push_group(8'h10, 0, 2);
        run(0, 12, 0, 1'b0, 1'b0, "t2stall");
        sample(0, ir, ov, od, oh, ol);
        check("t2 pending_inputs", 64'(in_q.size()), 64'(3));
        check("t2 in_ready_low", 64'(ir), 64'(0));
        check("t2 out_valid", 64'(ov), 64'(1));
        check("t2 held_data", 64'(od), 64'(tile(8'h10)));
        check("t2 held_head", 64'(oh), 64'(0));
        run(0, 100, 1, 1'b0, 1'b1, "t2");
        check("t2 sixth_out_cycle", 64'(g_out_cyc[5]), 64'(5));
        check("t2 in_ready_return", 64'(g_ir_rise), 64'(6));

        // Random handshakes over 8 token blocks
        do_reset();
        for (int b = 0; b < 8; b++) push_block(2, 2, 8'(b * 4));
        run(0, 3000, 2, 1'b1, 1'b1, "t3");

        // Head index wrap across consecutive blocks
        do_reset();
        push_block(2, 2, 8'h10);
        push_block(2, 2, 8'h18);
        run(0, 100, 1, 1'b0, 1'b1, "t6");

        // Mode sweep: MHA and MQA instances
        do_reset();
        push_block(1, 4, 8'h10);
        run(1, 100, 1, 1'b0, 1'b1, "t4mha");
        push_block(4, 1, 8'h10);
        run(2, 100, 1, 1'b0, 1'b1, "t4mqa");

        // Reset while output beat 4 is presented
        do_reset();
        push_block(2, 2, 8'h10);
        run(0, 6, 1, 1'b0, 1'b0, "t5pre");
        sample(0, ir, ov, od, oh, ol);
        check("t5 beat4_data", 64'(od), 64'(tile(8'h10)));
        check("t5 beat4_head", 64'(oh), 64'(1));
        #2 rst = 1'b1;
        #1;
        sample(0, ir, ov, od, oh, ol);
        check("t5 rst out_valid", 64'(ov), 64'(0));
        check("t5 rst in_ready", 64'(ir), 64'(1));
        check("t5 rst out_data", 64'(od), 64'(0));
        check("t5 rst head_idx", 64'(oh), 64'(0));
        check("t5 rst out_last", 64'(ol), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        in_q.delete();
        exp_q.delete();
        push_group(8'h30, 0, 2);
        run(0, 40, 1, 1'b0, 1'b1, "t5");
        run(0, 8, 1, 1'b0, 1'b0, "t5idle");
        sample(0, ir, ov, od, oh, ol);
        check("t5 no_stale_valid", 64'(ov), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
